// File: rtl/sub16_serial.sv
// sub16_serial: bit-serial subtractor, diff = a + ~b + 1 through one shared adder slice.
// Latency: acceptance edge through DONE entry spans STEPS+1 clock edges; one result per STEPS+2 clocks at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready (unbounded stall).
// Optional feature macro SUB16_SERIAL_OVF_EN adds the signed overflow output 'ovf'.
module sub16_serial #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zr,
  output logic             ng
`ifdef SUB16_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS  = WIDTH / BITS_PER_CYCLE;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q;
  logic [WIDTH-1:0]         sa_q;
  logic [WIDTH-1:0]         sb_q;
  logic [WIDTH-1:0]         res_q;
  logic                     carry_q;
  logic [STEP_W-1:0]        step_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [WIDTH-1:0]         diff_q;
  logic                     borrow_q;
  logic                     zr_q;
  logic                     ng_q;

  // Shared adder slice and the values it feeds back each RUN cycle
  logic [BITS_PER_CYCLE:0]              slice_d;
  logic [WIDTH+BITS_PER_CYCLE-1:0]      shifted_d;
  logic [WIDTH-1:0]                     res_d;
  logic [WIDTH-1:0]                     sa_d;
  logic [WIDTH-1:0]                     sb_d;
  logic                                 carry_d;

`ifdef SUB16_SERIAL_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;
  logic ovf_d;
`endif

  // One slice of the ripple: low bits of both operands plus carry, sum enters result from the MSB side
  always_comb begin
    slice_d   = {1'b0, sa_q[BITS_PER_CYCLE-1:0]} + {1'b0, sb_q[BITS_PER_CYCLE-1:0]}
              + {{BITS_PER_CYCLE{1'b0}}, carry_q};
    shifted_d = {slice_d[BITS_PER_CYCLE-1:0], res_q};
    res_d     = shifted_d[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
    sa_d      = sa_q >> BITS_PER_CYCLE;
    sb_d      = sb_q >> BITS_PER_CYCLE;
    carry_d   = slice_d[BITS_PER_CYCLE];
  end

`ifdef SUB16_SERIAL_OVF_EN
  // Signed overflow: operand signs differ and the result sign departs from the minuend's
  always_comb begin
    ovf_d = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
  end
`endif

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      step_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
`ifdef SUB16_SERIAL_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            // Two's complement subtraction: invert b and seed the carry with 1
            sa_q       <= a;
            sb_q       <= ~b;
            res_q      <= '0;
            carry_q    <= 1'b1;
            step_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
`ifdef SUB16_SERIAL_OVF_EN
            a_msb_q    <= a[WIDTH-1];
            b_msb_q    <= b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          sa_q    <= sa_d;
          sb_q    <= sb_d;
          res_q   <= res_d;
          carry_q <= carry_d;
          step_q  <= step_q + 1'b1;
          if (step_q == LAST_STEP) begin
            // Final slice: publish result and all flags on the same edge
            diff_q      <= res_d;
            borrow_q    <= ~carry_d;
            zr_q        <= (res_d == '0);
            ng_q        <= res_d[WIDTH-1];
`ifdef SUB16_SERIAL_OVF_EN
            ovf_q       <= ovf_d;
`endif
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
`ifdef SUB16_SERIAL_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_sub16_serial.sv
// tb_sub16_serial: directed and random checks of sub16_serial against an arithmetic model.
// Instance 0 resolves one bit per cycle, instance 1 resolves four bits per cycle.
// Latency is counted in clock edges from the acceptance edge through the edge raising out_valid.
module tb_sub16_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid_s  [2];
  logic        in_ready_s  [2];
  logic [15:0] a_s         [2];
  logic [15:0] b_s         [2];
  logic        out_valid_s [2];
  logic        out_ready_s [2];
  logic [15:0] diff_s      [2];
  logic        borrow_s    [2];
  logic        zr_s        [2];
  logic        ng_s        [2];
`ifdef SUB16_SERIAL_OVF_EN
  logic        ovf_s       [2];
`endif

  int checks;
  int failures;

  sub16_serial #(.WIDTH(16), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s[0]), .b(b_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .diff(diff_s[0]), .borrow(borrow_s[0]), .zr(zr_s[0]), .ng(ng_s[0])
`ifdef SUB16_SERIAL_OVF_EN
    , .ovf(ovf_s[0])
`endif
  );

  sub16_serial #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s[1]), .b(b_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .diff(diff_s[1]), .borrow(borrow_s[1]), .zr(zr_s[1]), .ng(ng_s[1])
`ifdef SUB16_SERIAL_OVF_EN
    , .ovf(ovf_s[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on instance k: accept, wait for result, optional stall, handshake
  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv, input int stall);
    int          n;
    int          exp_lat;
    int          sdiff;
    logic [16:0] wide;
    logic [15:0] exp_diff;
    logic        exp_borrow;
    logic        exp_ovf;

    wide       = {1'b0, av} - {1'b0, bv};
    exp_diff   = wide[15:0];
    exp_borrow = (av < bv);
    sdiff      = int'($signed(av)) - int'($signed(bv));
    exp_ovf    = (sdiff > 32767) || (sdiff < -32768);
    exp_lat    = (k == 0) ? 17 : 5;

    n = 0;
    while (in_ready_s[k] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready_s[k]}, 32'd1);

    out_ready_s[k] = (stall == 0);
    a_s[k]         = av;
    b_s[k]         = bv;
    in_valid_s[k]  = 1'b1;
    tick();
    in_valid_s[k]  = 1'b0;
    a_s[k]         = $urandom;
    b_s[k]         = $urandom;

    n = 1;
    while (out_valid_s[k] !== 1'b1 && n < 60) begin
      chk("in_ready_low_busy", {31'd0, in_ready_s[k]}, 32'd0);
      tick();
      n++;
    end
    chk("latency", n, exp_lat);
    chk("diff", {16'd0, diff_s[k]}, {16'd0, exp_diff});
    chk("borrow", {31'd0, borrow_s[k]}, {31'd0, exp_borrow});
    chk("zr", {31'd0, zr_s[k]}, {31'd0, (exp_diff == 16'd0)});
    chk("ng", {31'd0, ng_s[k]}, {31'd0, exp_diff[15]});
`ifdef SUB16_SERIAL_OVF_EN
    chk("ovf", {31'd0, ovf_s[k]}, {31'd0, exp_ovf});
`else
    if (exp_ovf) n = n;
`endif

    // Stall: result held and a presented operand must not be taken
    for (int i = 0; i < stall; i++) begin
      in_valid_s[k] = 1'b1;
      a_s[k]        = ~av;
      b_s[k]        = bv ^ 16'h00F0;
      tick();
      chk("stall_out_valid", {31'd0, out_valid_s[k]}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready_s[k]}, 32'd0);
      chk("stall_diff", {16'd0, diff_s[k]}, {16'd0, exp_diff});
      chk("stall_borrow", {31'd0, borrow_s[k]}, {31'd0, exp_borrow});
    end
    in_valid_s[k]  = 1'b0;
    out_ready_s[k] = 1'b1;
    tick();
    out_ready_s[k] = 1'b0;
    chk("post_hs_out_valid", {31'd0, out_valid_s[k]}, 32'd0);
    chk("post_hs_in_ready", {31'd0, in_ready_s[k]}, 32'd1);
    chk("post_hs_diff_held", {16'd0, diff_s[k]}, {16'd0, exp_diff});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid_s[k]  = 1'b0;
      out_ready_s[k] = 1'b0;
      a_s[k]         = 16'hDEAD;
      b_s[k]         = 16'hBEEF;
    end

    // Reset state
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", {31'd0, in_ready_s[k]}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid_s[k]}, 32'd0);
      chk("rst_diff", {16'd0, diff_s[k]}, 32'd0);
      chk("rst_flags", {29'd0, borrow_s[k], zr_s[k], ng_s[k]}, 32'd0);
`ifdef SUB16_SERIAL_OVF_EN
      chk("rst_ovf", {31'd0, ovf_s[k]}, 32'd0);
`endif
    end
    rst_n = 1'b1;
    tick();

    // Directed arithmetic cases
    run_op(0, 16'd5, 16'd3, 0);
    run_op(0, 16'd0, 16'd1, 0);
    run_op(0, 16'h1234, 16'h1234, 0);
    run_op(0, 16'd0, 16'd0, 0);
    run_op(0, 16'h8000, 16'd1, 0);
    run_op(0, 16'h7FFF, 16'hFFFF, 0);
    run_op(0, 16'd3, 16'd1, 0);
    run_op(1, 16'h0100, 16'h0001, 0);
    run_op(1, 16'h8000, 16'h0001, 0);

    // Backpressure, then an immediate follow-on operand
    run_op(0, 16'hA5A5, 16'h5A5A, 5);
    run_op(0, 16'h0042, 16'h0001, 0);
    run_op(1, 16'h0003, 16'hFFFF, 3);

    // Reset in the middle of a run discards it
    a_s[0]        = 16'h4444;
    b_s[0]        = 16'h1111;
    in_valid_s[0] = 1'b1;
    tick();
    in_valid_s[0] = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_in_ready", {31'd0, in_ready_s[0]}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid_s[0]}, 32'd0);
    chk("midrst_diff", {16'd0, diff_s[0]}, 32'd0);
    chk("midrst_flags", {29'd0, borrow_s[0], zr_s[0], ng_s[0]}, 32'd0);
    repeat (20) tick();
    chk("midrst_no_result", {31'd0, out_valid_s[0]}, 32'd0);
    run_op(0, 16'd9, 16'd4, 0);

    // Random pairs on both slice widths
    for (int i = 0; i < 1000; i++) begin
      run_op(0, 16'($urandom), 16'($urandom), (i % 50 == 7) ? 2 : 0);
    end
    for (int i = 0; i < 1000; i++) begin
      run_op(1, 16'($urandom), 16'($urandom), (i % 50 == 9) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
